// File: rtl/switch_control_pkg.sv
// ============================================================================
// Module      : switch_control_pkg
// Description : Shared sizing constants and helpers for the switch allocator.
// Revision    : 1.0 - initial release
// ============================================================================
`include "config.sv"
`default_nettype none
package switch_control_pkg;
  localparam int N_IN            = `N;
  localparam int M_OUT           = `M;
  localparam int CREDITS_DEFAULT = `SWITCH_CREDITS_DEFAULT;
  localparam int PTR_W           = (N_IN > 1) ? $clog2(N_IN) : 1;

  // Keeps only the lowest set bit.
  function automatic logic [M_OUT-1:0] lowest_one(input logic [M_OUT-1:0] v);
    return v & (~v + M_OUT'(1));
  endfunction
endpackage
`default_nettype wire

// File: rtl/switch_control_if.sv
// ============================================================================
// Module      : switch_control_if
// Description : Request/credit/grant bundle between agent stage and allocator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
interface switch_control_if;
  import switch_control_pkg::*;

  logic [0:N_IN-1][0:M_OUT-1] i_output_req;
  logic [0:N_IN-1]            i_ant;
  logic [0:M_OUT-1]           i_credit_return;
  logic [0:M_OUT-1][0:N_IN-1] o_grant;
  logic [0:M_OUT-1]           o_output_val;
  logic [0:N_IN-1]            o_input_pop;
  logic                       o_credit_err;

  modport master (
    output i_output_req, i_ant, i_credit_return,
    input  o_grant, o_output_val, o_input_pop, o_credit_err
  );

  modport slave (
    input  i_output_req, i_ant, i_credit_return,
    output o_grant, o_output_val, o_input_pop, o_credit_err
  );
endinterface
`default_nettype wire

// File: rtl/config.sv
// ============================================================================
// Module      : config (shared switch configuration)
// Description : Port counts and default downstream credit depth.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`ifndef SWITCH_CONFIG_SV
`define SWITCH_CONFIG_SV
`define N 5
`define M 5
`define SWITCH_CREDITS_DEFAULT 4
`endif
`default_nettype wire

// File: rtl/switch_control_rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick with an optional priority class.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
module rr_arbiter
  import switch_control_pkg::*;
#(
  parameter int WIDTH = N_IN,
  parameter int IDX_W = PTR_W
) (
  input  logic [WIDTH-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  input  logic [WIDTH-1:0] i_prio,
  output logic [WIDTH-1:0] o_gnt
);
  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_pool;
  logic             w_found;

  always_comb begin
    w_hi    = i_req & i_prio;
    w_pool  = (|w_hi) ? w_hi : i_req;
    o_gnt   = '0;
    w_found = 1'b0;
    // Search [ptr, WIDTH-1] first, then wrap to [0, ptr-1].
    for (int i = 0; i < WIDTH; i++) begin
      if (!w_found && w_pool[i] && (i >= int'(i_ptr))) begin
        o_gnt[i] = 1'b1;
        w_found  = 1'b1;
      end
    end
    for (int i = 0; i < WIDTH; i++) begin
      if (!w_found && w_pool[i]) begin
        o_gnt[i] = 1'b1;
        w_found  = 1'b1;
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/switch_control.sv
// ============================================================================
// Module      : switch_control
// Description : Credit-aware per-output round-robin switch allocator.
//               Define SWITCH_ANT_PRIORITY_EN to let ant packets win arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
module switch_control
  import switch_control_pkg::*;
#(
  parameter int CREDITS = CREDITS_DEFAULT
) (
  input  logic            clk,
  input  logic            reset_n,
  switch_control_if.slave bus
);
  localparam int                 c_cnt_w = $clog2(CREDITS + 1);
  localparam logic [c_cnt_w-1:0] c_full  = c_cnt_w'(CREDITS);
  localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

  logic                       r_ready;
  logic [PTR_W-1:0]           r_rr     [M_OUT];
  logic [c_cnt_w-1:0]         r_credit [M_OUT];
  logic [0:M_OUT-1][0:N_IN-1] r_grant;
  logic [0:M_OUT-1]           r_val;
  logic [0:N_IN-1]            r_pop;
  logic                       r_err;

  logic [M_OUT-1:0]           w_raw     [N_IN];
  logic [M_OUT-1:0]           w_lo      [N_IN];
  logic [M_OUT-1:0]           w_elig;
  logic [N_IN-1:0]            w_prio;
  logic [N_IN-1:0]            w_arb_req [M_OUT];
  logic [N_IN-1:0]            w_arb_gnt [M_OUT];
  logic [0:M_OUT-1][0:N_IN-1] w_grant;
  logic [0:M_OUT-1]           w_val;
  logic [0:N_IN-1]            w_pop;
  logic [PTR_W-1:0]           w_rr_nxt  [M_OUT];
  logic                       w_unused_bits;

  assign w_unused_bits = ^{bus.i_ant, bus.i_credit_return[0]};

`ifdef SWITCH_ANT_PRIORITY_EN
  always_comb begin
    w_prio = '0;
    for (int i = 0; i < N_IN; i++) w_prio[i] = bus.i_ant[i];
  end
`else
  assign w_prio = '0;
`endif

  // Requests are held off for one edge after reset and while the head is popping.
  always_comb begin
    w_raw     = '{default: '0};
    w_lo      = '{default: '0};
    w_elig    = '0;
    w_arb_req = '{default: '0};
    for (int i = 0; i < N_IN; i++) begin
      for (int m = 0; m < M_OUT; m++) w_raw[i][m] = bus.i_output_req[i][m];
      w_lo[i] = lowest_one(w_raw[i]);
    end
    for (int m = 0; m < M_OUT; m++) begin
      w_elig[m] = (m == 0) || (r_credit[m] != '0);
      for (int i = 0; i < N_IN; i++)
        w_arb_req[m][i] = r_ready & ~r_pop[i] & w_lo[i][m] & w_elig[m];
    end
  end

  for (genvar m = 0; m < M_OUT; m++) begin : g_arb
    rr_arbiter #(
      .WIDTH (N_IN),
      .IDX_W (PTR_W)
    ) u_arb (
      .i_req  (w_arb_req[m]),
      .i_ptr  (r_rr[m]),
      .i_prio (w_prio),
      .o_gnt  (w_arb_gnt[m])
    );
  end

  always_comb begin
    w_grant  = '0;
    w_val    = '0;
    w_pop    = '0;
    w_rr_nxt = r_rr;
    for (int m = 0; m < M_OUT; m++) begin
      w_val[m] = |w_arb_gnt[m];
      for (int i = 0; i < N_IN; i++) begin
        w_grant[m][i] = w_arb_gnt[m][i];
        w_pop[i]      = w_pop[i] | w_arb_gnt[m][i];
        if (w_arb_gnt[m][i]) w_rr_nxt[m] = (i == N_IN - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ready <= 1'b0;
      r_grant <= '0;
      r_val   <= '0;
      r_pop   <= '0;
      r_err   <= 1'b0;
      for (int m = 0; m < M_OUT; m++) begin
        r_rr[m]     <= '0;
        r_credit[m] <= c_full;
      end
    end else begin
      r_ready <= 1'b1;
      r_grant <= w_grant;
      r_val   <= w_val;
      r_pop   <= w_pop;
      for (int m = 0; m < M_OUT; m++) r_rr[m] <= w_rr_nxt[m];
      // Output 0 feeds the local PE and has no credit counter.
      for (int m = 1; m < M_OUT; m++) begin
        case ({w_val[m], bus.i_credit_return[m]})
          2'b10: r_credit[m] <= r_credit[m] - c_one;
          2'b01: begin
            if (r_credit[m] == c_full) r_err <= 1'b1;
            else                       r_credit[m] <= r_credit[m] + c_one;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.o_grant      = r_grant;
  assign bus.o_output_val = r_val;
  assign bus.o_input_pop  = r_pop;
  assign bus.o_credit_err = r_err;
endmodule
`default_nettype wire

// File: tb/tb_switch_control.sv
// ============================================================================
// Module      : tb_switch_control
// Description : Directed and randomized checks of switch_control against a
//               behavioural allocator model (honours SWITCH_ANT_PRIORITY_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
module tb_switch_control;
  import switch_control_pkg::*;

  localparam int CRED = 4;
`ifdef SWITCH_ANT_PRIORITY_EN
  localparam bit ANT_EN = 1'b1;
`else
  localparam bit ANT_EN = 1'b0;
`endif

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp   = 0;
  int   n_bad   = 0;

  int                         m_credit [M_OUT];
  int                         m_rr     [M_OUT];
  bit                         m_err;
  bit                         m_ready;
  logic [0:M_OUT-1][0:N_IN-1] exp_grant;
  logic [0:M_OUT-1]           exp_val;
  logic [0:N_IN-1]            exp_pop;

  switch_control_if bus ();

  switch_control #(.CREDITS(CRED)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] dut_credits();
    logic [63:0] v = '0;
    for (int m = 1; m < M_OUT; m++) v = (v << 4) | 64'(dut.r_credit[m]);
    return v;
  endfunction

  function automatic logic [63:0] dut_rr();
    logic [63:0] v = '0;
    for (int m = 0; m < M_OUT; m++) v = (v << 4) | 64'(dut.r_rr[m]);
    return v;
  endfunction

  function automatic logic [63:0] model_credits();
    logic [63:0] v = '0;
    for (int m = 1; m < M_OUT; m++) v = (v << 4) | 64'(m_credit[m]);
    return v;
  endfunction

  function automatic logic [63:0] model_rr();
    logic [63:0] v = '0;
    for (int m = 0; m < M_OUT; m++) v = (v << 4) | 64'(m_rr[m]);
    return v;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < M_OUT; m++) begin
      m_credit[m] = CRED;
      m_rr[m]     = 0;
    end
    m_err     = 1'b0;
    m_ready   = 1'b0;
    exp_grant = '0;
    exp_val   = '0;
    exp_pop   = '0;
  endtask

  // Each output picks the requester closest after its pointer (ant class first).
  task automatic model_step();
    int want [N_IN];
    int best, best_key, key;
    logic [0:M_OUT-1][0:N_IN-1] g;
    g = '0;
    if (!m_ready) begin
      m_ready = 1'b1;
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        want[i] = -1;
        if (!exp_pop[i])
          for (int m = M_OUT - 1; m >= 0; m--)
            if (bus.i_output_req[i][m]) want[i] = m;
      end
      for (int m = 0; m < M_OUT; m++) begin
        if (m == 0 || m_credit[m] > 0) begin
          best = -1;
          best_key = 1000;
          for (int i = 0; i < N_IN; i++) begin
            if (want[i] == m) begin
              key = ((ANT_EN && !bus.i_ant[i]) ? N_IN : 0) + (i - m_rr[m] + N_IN) % N_IN;
              if (key < best_key) begin
                best_key = key;
                best = i;
              end
            end
          end
          if (best >= 0) begin
            g[m][best] = 1'b1;
            m_rr[m] = (best + 1) % N_IN;
          end
        end
      end
    end
    for (int m = 1; m < M_OUT; m++) begin
      if ((|g[m]) && !bus.i_credit_return[m]) m_credit[m] = m_credit[m] - 1;
      else if (!(|g[m]) && bus.i_credit_return[m]) begin
        if (m_credit[m] == CRED) m_err = 1'b1;
        else m_credit[m] = m_credit[m] + 1;
      end
    end
    exp_grant = g;
    for (int m = 0; m < M_OUT; m++) exp_val[m] = |g[m];
    for (int i = 0; i < N_IN; i++) begin
      exp_pop[i] = 1'b0;
      for (int m = 0; m < M_OUT; m++) exp_pop[i] = exp_pop[i] | g[m][i];
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    check("grant", 64'(bus.o_grant), 64'(exp_grant));
    check("val", 64'(bus.o_output_val), 64'(exp_val));
    check("pop", 64'(bus.o_input_pop), 64'(exp_pop));
    check("credit_err", 64'(bus.o_credit_err), 64'(m_err));
    check("credits", dut_credits(), model_credits());
    check("rr", dut_rr(), model_rr());
  end

  task automatic rand_phase(input int n);
    int r;
    repeat (n) begin
      @(negedge clk);
      for (int i = 0; i < N_IN; i++) begin
        r = $urandom_range(0, 3);
        bus.i_output_req[i] = '0;
        if (r == 1) bus.i_output_req[i] = M_OUT'($urandom);
        else if (r >= 2) bus.i_output_req[i][$urandom_range(0, M_OUT - 1)] = 1'b1;
      end
      bus.i_ant = N_IN'($urandom);
      bus.i_credit_return[0] = 1'($urandom_range(0, 1));
      for (int m = 1; m < M_OUT; m++)
        bus.i_credit_return[m] = ((m_credit[m] < CRED) && ($urandom_range(0, 2) == 0))
                                 || ($urandom_range(0, 199) == 0);
    end
  endtask

  logic [0:N_IN-1] seq [6];

  initial begin
    bus.i_output_req    = '0;
    bus.i_ant           = '0;
    bus.i_credit_return = '0;
    repeat (2) @(negedge clk);
    check("rst_grant", 64'(bus.o_grant), 64'd0);
    check("rst_pop", 64'(bus.o_input_pop), 64'd0);
    check("rst_err", 64'(bus.o_credit_err), 64'd0);
    check("rst_credits", dut_credits(), 64'h4444);
    check("rst_rr", dut_rr(), 64'd0);

    // Request present at release: first edge must not grant.
    reset_n = 1'b1;
    bus.i_output_req[2][1] = 1'b1;
    @(negedge clk);
    check("release_first_edge", 64'(bus.o_grant), 64'd0);
    @(negedge clk);
    check("out1_grant", 64'(bus.o_grant[1]), 64'b00100);
    check("out1_pop", 64'(bus.o_input_pop), 64'b00100);
    check("out1_credit", 64'(dut.r_credit[1]), 64'd3);
    bus.i_output_req = '0;
    @(negedge clk);
    check("no_persist", 64'(bus.o_grant), 64'd0);

    // Move rr[2] to 1, restore its credit, then three requesters for 6 cycles.
    bus.i_output_req[0][2] = 1'b1;
    @(negedge clk);
    bus.i_output_req = '0;
    @(negedge clk);
    bus.i_credit_return[2] = 1'b1;
    @(negedge clk);
    bus.i_credit_return = '0;
    check("out2_refill", 64'(dut.r_credit[2]), 64'd4);
    check("out2_rr", 64'(dut.r_rr[2]), 64'd1);
    seq = '{5'b01000, 5'b00010, 5'b10000, 5'b01000, 5'b00000, 5'b00000};
    bus.i_output_req[0][2] = 1'b1;
    bus.i_output_req[1][2] = 1'b1;
    bus.i_output_req[3][2] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("rr_order%0d", k), 64'(bus.o_grant[2]), 64'(seq[k]));
    end
    bus.i_output_req = '0;
    check("out2_empty", 64'(dut.r_credit[2]), 64'd0);

    // Drain output 3, then request and return together.
    bus.i_output_req[0][3] = 1'b1;
    bus.i_output_req[1][3] = 1'b1;
    repeat (8) @(negedge clk);
    bus.i_output_req = '0;
    @(negedge clk);
    check("out3_drained", 64'(dut.r_credit[3]), 64'd0);
    bus.i_output_req[4][3] = 1'b1;
    bus.i_credit_return[3] = 1'b1;
    @(negedge clk);
    bus.i_credit_return = '0;
    check("out3_same_cycle", 64'(bus.o_grant[3]), 64'd0);
    check("out3_credit_up", 64'(dut.r_credit[3]), 64'd1);
    @(negedge clk);
    bus.i_output_req = '0;
    check("out3_next_grant", 64'(bus.o_grant[3]), 64'b00001);
    check("out3_credit_back", 64'(dut.r_credit[3]), 64'd0);

    // Return on a full counter.
    bus.i_credit_return[4] = 1'b1;
    @(negedge clk);
    bus.i_credit_return = '0;
    check("out4_saturate", 64'(dut.r_credit[4]), 64'd4);
    check("err_set", 64'(bus.o_credit_err), 64'd1);
    repeat (3) @(negedge clk);
    check("err_sticky", 64'(bus.o_credit_err), 64'd1);

    bus.i_ant[4] = 1'b1;
    bus.i_output_req[1][0] = 1'b1;
    bus.i_output_req[4][0] = 1'b1;
    @(negedge clk);
    bus.i_output_req = '0;
    bus.i_ant = '0;
    check("ant_priority", 64'(bus.o_grant[0]), ANT_EN ? 64'b00001 : 64'b01000);

    rand_phase(800);

    // Reset pulse in the middle of traffic.
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_grant", 64'(bus.o_grant), 64'd0);
    check("midrst_val", 64'(bus.o_output_val), 64'd0);
    check("midrst_pop", 64'(bus.o_input_pop), 64'd0);
    check("midrst_err", 64'(bus.o_credit_err), 64'd0);
    check("midrst_credits", dut_credits(), 64'h4444);
    check("midrst_rr", dut_rr(), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    rand_phase(800);
    @(negedge clk);
    bus.i_output_req    = '0;
    bus.i_credit_return = '0;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/switch_control.md
SWITCH_CONTROL -- requirements
Module: switch_control

Interface
REQ-001 SHALL have parameter CREDITS, default 4: per-output downstream buffer depth; legal range 1..15.
REQ-002 SHALL take port counts from the shared config, not as parameters: `N inputs, `M outputs, both 5; index 0 = local PE.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 i_output_req  in  [0:`N-1][0:`M-1]  per-input requested output, from the agent stage.
REQ-006 i_ant  in  [0:`N-1]  head packet of input i is an ant packet.
REQ-007 i_credit_return  in  [0:`M-1]  one-cycle pulse: one downstream slot freed on output m.
REQ-008 o_grant  out  [0:`M-1][0:`N-1]  registered one-hot input select per output, to the crossbar.
REQ-009 o_output_val  out  [0:`M-1]  registered: output m carries a packet this cycle.
REQ-010 o_input_pop  out  [0:`N-1]  registered: input FIFO i dequeues this cycle.
REQ-011 o_credit_err  out  1  registered sticky flag: credit returned while the counter is already full.

Function
REQ-012 Requests SHALL be sampled in cycle t; the resulting grant, val and pop SHALL be visible in cycle t+1 (latency 1), all three asserted together.
REQ-013 An input whose request has more than one bit set SHALL be treated as requesting only its lowest-index set output.
REQ-014 An input with o_input_pop high in the current cycle SHALL be masked from arbitration in that cycle, so the same head is never granted twice.
REQ-015 Output m (m != 0) SHALL be eligible only when its credit counter > 0; output 0 SHALL always be eligible, with no counter.
REQ-016 Each output SHALL grant at most one input per cycle by round-robin from its pointer rr[m]: the first requesting input at index >= rr[m], wrapping from `N-1 to 0.
REQ-017 After a grant to input k, rr[m] SHALL become (k+1) mod `N; with no grant, rr[m] SHALL be unchanged.
REQ-018 Each credit counter (m != 0) SHALL decrement on grant and increment on i_credit_return; on a simultaneous grant and return it SHALL be unchanged.
REQ-019 A return with the counter at CREDITS and no grant SHALL leave the counter at CREDITS and set o_credit_err; the counter SHALL never wrap.
REQ-020 Granted requests not asserted in t+1 SHALL produce o_grant, o_output_val and o_input_pop all zero in t+1; grants never persist without a request.
REQ-021 Each input SHALL receive at most one grant per cycle, and o_input_pop[i] SHALL equal the OR over m of o_grant[m][i].

Reset
REQ-022 On reset_n low, asynchronously: o_grant, o_output_val, o_input_pop and o_credit_err SHALL be 0, rr[m] SHALL be 0, and credit counters SHALL be CREDITS.
REQ-023 Reset asserted mid-operation SHALL discard in-flight grants; the first grant after deassertion SHALL appear no earlier than the second rising edge.

Configuration
REQ-024 Macro SWITCH_ANT_PRIORITY_EN defined: per output, requesting inputs with i_ant=1 SHALL win over i_ant=0 inputs; round-robin from rr[m] SHALL apply within the winning class; rr update is unchanged.
REQ-025 SWITCH_ANT_PRIORITY_EN undefined: i_ant SHALL be ignored and arbitration SHALL be pure round-robin.

Structure
REQ-026 `N, `M and CREDITS default SHALL live in config.sv; the credit-count width SHALL be $clog2(CREDITS+1).
REQ-027 Round-robin selection SHALL be a sub-module rr_arbiter (`N-bit request, pointer, and optional priority vector in; one-hot grant out), instantiated `M times.

Verification
REQ-028 Reset, then input 2 requests output 1 for one cycle -> next cycle o_grant[1]=00100, o_input_pop=00100, credit[1]=3.
REQ-029 Inputs 0, 1, 3 hold a request for output 2 for 6 cycles, no credit returns, CREDITS=4 -> grant order 1,3,0,1 in consecutive cycles, then no grant until a credit return.
REQ-030 Output 3 has credit 0, a request and a credit return in the same cycle -> no grant that cycle, grant the next cycle, counter back to 0.
REQ-031 Credit return on output 4 at counter 4 -> counter stays 4, o_credit_err=1 until reset.
REQ-032 With SWITCH_ANT_PRIORITY_EN, inputs 1 (normal) and 4 (ant) request output 0, rr=0 -> input 4 granted first; without the macro -> input 1 first.
REQ-033 reset_n pulsed low during continuous traffic -> all outputs 0 within the same cycle, counters back to CREDITS, rr back to 0.
